// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants, state encoding and the byte-wide CRC-32 step used by the
// transmit framer and the receive-side FCS checker.
package gmii_tx_framer_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_PRE,
      TX_SFD,
      TX_DATA,
      TX_PAD,
      TX_FCS,
      TX_IFG,
      TX_ABORT
   } tx_state_t;

   // Reflected CRC-32, one byte per call, LSB of the byte enters first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-CRC for one data byte; also instantiated by the FCS checker.
module crc32_d8
   import gmii_tx_framer_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  d_i,
   output logic [31:0] crc_o
);

   assign crc_o = crc32_byte(crc_i, d_i);

endmodule

// File: rtl/gmii_tx_framer.sv
// Per-port GMII transmit framer: preamble/SFD, payload, zero pad, FCS and
// inter-frame gap, with underrun / link-loss abort and drain.
module gmii_tx_framer
   import gmii_tx_framer_pkg::*;
#(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_PAYLOAD  = 60,
   parameter int unsigned IFG_LEN      = 12
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       link_sync_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   input  logic       in_last_i,
   output logic       in_ready_o,
   output logic [7:0] tx_data_o,
   output logic       tx_ctrl_o,
   output logic       frame_done_o,
   output logic       frame_abort_o
);

   localparam logic [7:0]  PRE_L   = 8'(PREAMBLE_LEN);
   localparam logic [15:0] MIN_PAY = 16'(MIN_PAYLOAD);
   localparam logic [15:0] IFG_L   = 16'(IFG_LEN);

   tx_state_t   state_q, state_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_ctrl_q, tx_ctrl_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;
   logic [7:0]  phase_q, phase_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] ifg_cnt_q, ifg_cnt_d;
   logic [31:0] crc_q, crc_d;

   logic [31:0] crc_nxt;
   logic [31:0] fcs_w;
   logic [7:0]  crc_din;
   logic [15:0] byte_inc;
   logic [15:0] ifg_inc;
   logic        accept;

   assign in_ready_o = ((state_q == TX_DATA) && link_sync_i) || (state_q == TX_ABORT);
   assign accept     = in_valid_i && in_ready_o;

   assign crc_din  = (state_q == TX_PAD) ? 8'h00 : in_data_i;
   assign fcs_w    = ~crc_q;
   assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign ifg_inc  = (ifg_cnt_q == 16'hFFFF) ? ifg_cnt_q : ifg_cnt_q + 16'd1;

   crc32_d8 u_crc (
      .crc_i (crc_q),
      .d_i   (crc_din),
      .crc_o (crc_nxt)
   );

   // Outputs are computed for the cycle after the edge, so each state
   // describes what the next edge will put on the wire.
   always_comb begin
      state_d    = state_q;
      tx_data_d  = 8'h00;
      tx_ctrl_d  = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      phase_d    = phase_q;
      byte_cnt_d = byte_cnt_q;
      ifg_cnt_d  = ifg_cnt_q;
      crc_d      = crc_q;
      unique case (state_q)
         TX_IDLE: begin
            if (in_valid_i && link_sync_i) begin
               tx_data_d  = PREAMBLE_BYTE;
               tx_ctrl_d  = 1'b1;
               phase_d    = 8'd1;
               byte_cnt_d = 16'd0;
               crc_d      = CRC32_INIT;
               state_d    = (PRE_L <= 8'd1) ? TX_SFD : TX_PRE;
            end
         end
         TX_PRE: begin
            tx_data_d = PREAMBLE_BYTE;
            tx_ctrl_d = 1'b1;
            phase_d   = phase_q + 8'd1;
            if (phase_q + 8'd1 >= PRE_L) state_d = TX_SFD;
         end
         TX_SFD: begin
            tx_data_d = SFD_BYTE;
            tx_ctrl_d = 1'b1;
            state_d   = TX_DATA;
         end
         TX_DATA: begin
            if (accept) begin
               tx_data_d  = in_data_i;
               tx_ctrl_d  = 1'b1;
               crc_d      = crc_nxt;
               byte_cnt_d = byte_inc;
               if (in_last_i) begin
                  phase_d = 8'd0;
                  state_d = (byte_inc < MIN_PAY) ? TX_PAD : TX_FCS;
               end
            end else begin
               // Underrun and link loss collapse into one abort; the abort
               // cycle itself is the first idle cycle of the gap.
               abort_d   = 1'b1;
               ifg_cnt_d = 16'd1;
               state_d   = TX_ABORT;
            end
         end
         TX_PAD: begin
            tx_ctrl_d  = 1'b1;
            crc_d      = crc_nxt;
            byte_cnt_d = byte_inc;
            if (byte_inc >= MIN_PAY) state_d = TX_FCS;
         end
         TX_FCS: begin
            tx_ctrl_d = 1'b1;
            phase_d   = phase_q + 8'd1;
            unique case (phase_q[1:0])
               2'd0: tx_data_d = fcs_w[7:0];
               2'd1: tx_data_d = fcs_w[15:8];
               2'd2: tx_data_d = fcs_w[23:16];
               default: tx_data_d = fcs_w[31:24];
            endcase
            if (phase_q[1:0] == 2'd3) begin
               done_d    = 1'b1;
               ifg_cnt_d = 16'd0;
               state_d   = (IFG_L == 16'd0) ? TX_IDLE : TX_IFG;
            end
         end
         TX_IFG: begin
            ifg_cnt_d = ifg_inc;
            if (ifg_inc >= IFG_L) state_d = TX_IDLE;
         end
         TX_ABORT: begin
            ifg_cnt_d = ifg_inc;
            if (accept && in_last_i) state_d = (ifg_inc >= IFG_L) ? TX_IDLE : TX_IFG;
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= TX_IDLE;
         tx_data_q  <= 8'h00;
         tx_ctrl_q  <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         phase_q    <= 8'd0;
         byte_cnt_q <= 16'd0;
         ifg_cnt_q  <= 16'd0;
         crc_q      <= CRC32_INIT;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_ctrl_q  <= tx_ctrl_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
         phase_q    <= phase_d;
         byte_cnt_q <= byte_cnt_d;
         ifg_cnt_q  <= ifg_cnt_d;
         crc_q      <= crc_d;
      end
   end

   assign tx_data_o     = tx_data_q;
   assign tx_ctrl_o     = tx_ctrl_q;
   assign frame_done_o  = done_q;
   assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench: dut0 runs with padding disabled, dut1 with default parameters.
module tb_gmii_tx_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, link, in_valid, in_last, en0, en1;
   logic [7:0] in_data;
   logic       rdy0, ctrl0, done0, abort0;
   logic [7:0] txd0;
   logic       rdy1, ctrl1, done1, abort1;
   logic [7:0] txd1;

   gmii_tx_framer #(.MIN_PAYLOAD(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .link_sync_i(link), .in_data_i(in_data),
      .in_valid_i(in_valid & en0), .in_last_i(in_last), .in_ready_o(rdy0),
      .tx_data_o(txd0), .tx_ctrl_o(ctrl0), .frame_done_o(done0), .frame_abort_o(abort0));

   gmii_tx_framer dut1 (
      .clk_i(clk), .rst_ni(rst_n), .link_sync_i(link), .in_data_i(in_data),
      .in_valid_i(in_valid & en1), .in_last_i(in_last), .in_ready_o(rdy1),
      .tx_data_o(txd1), .tx_ctrl_o(ctrl1), .frame_done_o(done1), .frame_abort_o(abort1));

   int nvec = 0;
   int nerr = 0;

   logic [7:0] pay[$];
   bit         lst[$];
   int         idx, gap_at;
   bit         gap_used;
   logic [7:0] lg_d[$];
   bit         lg_c[$], lg_dn[$], lg_ab[$];
   logic [7:0] cap[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference CRC, data bit fed in against the register LSB.
   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r = c;
      for (int k = 0; k < 8; k++) begin
         logic fb = r[0] ^ b[k];
         r = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   task automatic add_frame(input int len, input int base, input int step);
      for (int i = 0; i < len; i++) begin
         pay.push_back(8'((base + i * step) & 255));
         lst.push_back(i == len - 1);
      end
   endtask

   task automatic clear();
      pay.delete(); lst.delete(); lg_d.delete(); lg_c.delete(); lg_dn.delete(); lg_ab.delete();
      idx = 0; gap_at = -1; gap_used = 0;
   endtask

   task automatic tick();
      bit acc;
      if (idx < pay.size() && !(idx == gap_at && !gap_used)) begin
         in_valid = 1'b1; in_data = pay[idx]; in_last = lst[idx];
      end else begin
         in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
         if (idx == gap_at) gap_used = 1;
      end
      @(negedge clk);
      acc = in_valid && (en0 ? rdy0 : rdy1);
      @(posedge clk); #1;
      if (acc) idx++;
      lg_d.push_back(en0 ? txd0 : txd1);
      lg_c.push_back(en0 ? ctrl0 : ctrl1);
      lg_dn.push_back(en0 ? done0 : done1);
      lg_ab.push_back(en0 ? abort0 : abort1);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
      cap.delete();
      foreach (lg_c[i]) if (lg_c[i]) cap.push_back(lg_d[i]);
   endtask

   function automatic bit at(input int kind, input int i);
      return (kind == 0) ? lg_c[i] : (kind == 1) ? lg_dn[i] : lg_ab[i];
   endfunction

   function automatic int count_of(input int kind);
      int n = 0;
      for (int i = 0; i < lg_c.size(); i++) n += int'(at(kind, i));
      return n;
   endfunction

   function automatic int find_from(input int kind, input int from);
      for (int i = from; i < lg_c.size(); i++) if (at(kind, i)) return i;
      return -1;
   endfunction

   task automatic chk_frame(input string tag, input int off, input int first, input int len, input int minp);
      int plen = (len < minp) ? minp : len;
      logic [31:0] c = 32'hFFFFFFFF;
      if (cap.size() < off + 8 + plen + 4) begin
         chk({tag, "_caplen"}, cap.size(), off + 8 + plen + 4);
         return;
      end
      for (int i = 0; i < 7; i++) chk({tag, "_pre"}, cap[off + i], 8'h55);
      chk({tag, "_sfd"}, cap[off + 7], 8'hD5);
      for (int i = 0; i < plen; i++)
         chk({tag, "_body"}, cap[off + 8 + i], (i < len) ? pay[first + i] : 8'h00);
      for (int i = 0; i < plen + 4; i++) c = crc_bits(c, cap[off + 8 + i]);
      chk({tag, "_residue"}, c, 32'hDEBB20E3);
   endtask

   task automatic abort_case(input string tag, input int len1, input int exp_dist);
      int ab, s2;
      clear();
      add_frame(len1, 8'h10, 1);
      add_frame(10, 8'h80, 3);
      gap_at = 20;
      run(160);
      ab = find_from(2, 0);
      chk({tag, "_abort_cnt"}, count_of(2), 1);
      if (ab > 0) begin
         chk({tag, "_ctrl_at_abort"}, lg_c[ab], 0);
         chk({tag, "_last_before"}, lg_d[ab - 1], pay[19]);
         s2 = find_from(0, ab);
         chk({tag, "_restart_dist"}, s2 - ab, exp_dist);
         if (s2 > 0) chk({tag, "_restart_byte"}, lg_d[s2], 8'h55);
      end else begin
         chk({tag, "_abort_idx"}, ab, 1);
      end
      chk({tag, "_drained"}, idx, len1 + 10);
      chk({tag, "_done_cnt"}, count_of(1), 1);
      chk({tag, "_ctrl_cycles"}, count_of(0), 28 + 72);
      chk_frame({tag, "_f2"}, 28, len1, 10, 60);
   endtask

   initial begin
      logic [7:0] ex[$];
      int d1, s2, guard;
      rst_n = 0; link = 0; in_valid = 0; in_data = 0; in_last = 0; en0 = 0; en1 = 0;
      clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", txd1, 8'h00);
      chk("rst_ctrl", ctrl1, 0);
      chk("rst_ready", rdy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_abort", abort1, 0);
      chk("rst_ctrl0", ctrl0, 0);
      rst_n = 1;
      link = 1;

      // "123456789" without padding
      en0 = 1;
      clear();
      for (int i = 0; i < 9; i++) begin pay.push_back(8'h31 + 8'(i)); lst.push_back(i == 8); end
      run(40);
      chk("a_first55_next_cycle", lg_c[0], 1);
      chk("a_ctrl_cycles", count_of(0), 21);
      repeat (7) ex.push_back(8'h55);
      ex.push_back(8'hD5);
      for (int i = 0; i < 9; i++) ex.push_back(8'h31 + 8'(i));
      ex.push_back(8'h26); ex.push_back(8'h39); ex.push_back(8'hF4); ex.push_back(8'hCB);
      chk("a_cap_len", cap.size(), 21);
      for (int i = 0; i < 21 && i < cap.size(); i++) chk("a_byte", cap[i], ex[i]);
      chk("a_done_cnt", count_of(1), 1);
      d1 = find_from(1, 0);
      if (d1 >= 0) begin
         chk("a_done_byte", lg_d[d1], 8'hCB);
         chk("a_done_ctrl", lg_c[d1], 1);
      end else chk("a_done_idx", d1, 20);
      en0 = 0;

      // 14-byte frame padded to 60
      en1 = 1;
      clear();
      add_frame(14, 8'hA0, 3);
      run(100);
      chk("b_ctrl_cycles", count_of(0), 72);
      chk("b_done_cnt", count_of(1), 1);
      chk_frame("b", 0, 0, 14, 60);

      // two 64-byte frames, valid held high across the boundary
      clear();
      add_frame(64, 8'h00, 1);
      add_frame(64, 8'h40, 5);
      run(200);
      chk("c_ctrl_cycles", count_of(0), 152);
      chk("c_done_cnt", count_of(1), 2);
      d1 = find_from(1, 0);
      s2 = (d1 >= 0) ? find_from(0, d1 + 1) : -1;
      chk("c_ifg_len", s2 - d1 - 1, 12);
      if (s2 > 0) chk("c_next_55", lg_d[s2], 8'h55);
      chk_frame("c1", 0, 0, 64, 60);
      chk_frame("c2", 76, 64, 64, 60);

      // underrun after byte 20: short drain waits out the gap, long drain exceeds it
      abort_case("d22", 22, 12);
      abort_case("d40", 40, 21);

      // link down in IDLE holds off the start
      clear();
      add_frame(5, 8'h21, 1);
      link = 0;
      repeat (4) begin
         tick();
         chk("e_ctrl_link_down", lg_c[lg_c.size() - 1], 0);
         chk("e_ready_link_down", rdy1, 0);
      end
      link = 1;
      tick();
      chk("e_start_ctrl", lg_c[lg_c.size() - 1], 1);
      chk("e_start_byte", lg_d[lg_d.size() - 1], 8'h55);
      run(90);
      chk("e_done_cnt", count_of(1), 1);

      // reset in the middle of the FCS
      clear();
      add_frame(60, 8'h05, 7);
      guard = 0;
      while (idx < 60 && guard < 200) begin tick(); guard++; end
      chk("f_payload_sent", idx, 60);
      tick();
      chk("f_in_fcs_ctrl", ctrl1, 1);
      rst_n = 0;
      #1;
      chk("f_rst_ctrl_now", ctrl1, 0);
      chk("f_rst_data_now", txd1, 8'h00);
      chk("f_rst_done_now", done1, 0);
      @(posedge clk); #1;
      rst_n = 1;
      clear();
      run(10);
      chk("f_post_done", count_of(1), 0);
      chk("f_post_ctrl", count_of(0), 0);
      chk("f_post_ready", rdy1, 0);
      add_frame(5, 8'h11, 1);
      tick();
      chk("f_idle_restart", lg_c[lg_c.size() - 1], 1);
      chk("f_idle_restart_byte", lg_d[lg_d.size() - 1], 8'h55);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
